// File: rtl/conv_mac_array.sv
// rtl/conv_mac_array.sv - broadcast-activation multiply-accumulate array with lane-serial drain
// Optional macro CONV_MAC_ARRAY_SATURATE_EN: saturate scaled outputs instead of wrapping.
module conv_mac_array #(
  parameter int IO_DATA_WIDTH      = 16,
  parameter int ACCUMULATION_WIDTH = 32,
  parameter int NB_LANES           = 4,
  parameter int ACC_LEN_WIDTH      = 16,
  parameter int OUTPUT_SCALE       = 0
) (
  input  logic                              clk,
  input  logic                              arst_n_in,
  input  logic                              start,
  input  logic [ACC_LEN_WIDTH-1:0]          acc_len,
  output logic                              running,
  input  logic [IO_DATA_WIDTH-1:0]          a_input,
  input  logic                              a_zero_flag,
  input  logic                              a_valid,
  output logic                              a_ready,
  input  logic [NB_LANES*IO_DATA_WIDTH-1:0] b_input,
  input  logic                              b_valid,
  output logic                              b_ready,
  output logic [IO_DATA_WIDTH-1:0]          out,
  output logic [$clog2(NB_LANES)-1:0]       out_lane,
  output logic                              out_last,
  output logic                              output_valid,
  input  logic                              output_ready
);

  localparam int W  = IO_DATA_WIDTH;
  localparam int AW = ACCUMULATION_WIDTH;
  localparam int LW = $clog2(NB_LANES);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                   state_q, state_d;
  logic [ACC_LEN_WIDTH-1:0] len_q, cnt_q;
  logic [LW-1:0]            lane_q;
  logic signed [AW-1:0]     acc_q [NB_LANES];
  logic signed [2*W-1:0]    prod [NB_LANES];
  logic signed [W-1:0]      a_eff;
  logic signed [AW-1:0]     shifted;
  logic [W-1:0]             out_val;
  logic                     job_start, beat, last_beat, last_lane, xfer;

  assign job_start = (state_q == IDLE) && start && (acc_len != '0);
  assign beat      = (state_q == ACCUM) && a_valid && b_valid;
  assign last_beat = (cnt_q == len_q - ACC_LEN_WIDTH'(1));
  assign last_lane = (lane_q == LW'(NB_LANES - 1));
  assign xfer      = (state_q == DRAIN) && output_ready;

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d      = state_q;
    running      = 1'b0;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    output_valid = 1'b0;
    case (state_q)
      IDLE: if (job_start) state_d = ACCUM;
      ACCUM: begin
        running = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        if (beat && last_beat) state_d = DRAIN;
      end
      DRAIN: begin
        running      = 1'b1;
        output_valid = 1'b1;
        if (xfer && last_lane) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Products are formed at full 2*W precision, then sign-extended into the accumulator
  always_comb begin
    a_eff = a_zero_flag ? '0 : $signed(a_input);
    for (int i = 0; i < NB_LANES; i++) begin
      prod[i] = (2*W)'(a_eff) * (2*W)'($signed(b_input[i*W +: W]));
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      len_q  <= '0;
      cnt_q  <= '0;
      lane_q <= '0;
      for (int i = 0; i < NB_LANES; i++) acc_q[i] <= '0;
    end else begin
      if (job_start) begin
        len_q  <= acc_len;
        cnt_q  <= '0;
        lane_q <= '0;
        for (int i = 0; i < NB_LANES; i++) acc_q[i] <= '0;
      end
      if (beat) begin
        cnt_q <= cnt_q + ACC_LEN_WIDTH'(1);
        for (int i = 0; i < NB_LANES; i++) acc_q[i] <= acc_q[i] + AW'(prod[i]);
      end
      if (xfer) lane_q <= last_lane ? '0 : lane_q + LW'(1);
    end
  end

  assign shifted = acc_q[lane_q] >>> OUTPUT_SCALE;

`ifdef CONV_MAC_ARRAY_SATURATE_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-W+1){1'b1}}, {(W-1){1'b0}}};
  always_comb begin
    out_val = W'(shifted);
    if (shifted > SAT_MAX)      out_val = W'(SAT_MAX);
    else if (shifted < SAT_MIN) out_val = W'(SAT_MIN);
  end
`else
  always_comb begin
    out_val = W'(shifted);
  end
`endif

  assign out      = (state_q == DRAIN) ? out_val : '0;
  assign out_lane = lane_q;
  assign out_last = (state_q == DRAIN) && last_lane;

endmodule

// File: tb/tb_conv_mac_array.sv
// tb/tb_conv_mac_array.sv - directed-vector bench with arithmetic reference model for conv_mac_array
module tb_conv_mac_array;

  localparam int SCALE = 0;

  logic        clk = 1'b0;
  logic        arst_n_in = 1'b0;
  logic        start = 1'b0;
  logic [15:0] acc_len = '0;
  logic        running;
  logic [15:0] a_input = '0;
  logic        a_zero_flag = 1'b0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic [63:0] b_input = '0;
  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [15:0] out;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        output_valid;
  logic        output_ready = 1'b1;

  conv_mac_array #(
    .IO_DATA_WIDTH(16), .ACCUMULATION_WIDTH(32), .NB_LANES(4),
    .ACC_LEN_WIDTH(16), .OUTPUT_SCALE(SCALE)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .acc_len(acc_len),
    .running(running), .a_input(a_input), .a_zero_flag(a_zero_flag),
    .a_valid(a_valid), .a_ready(a_ready), .b_input(b_input), .b_valid(b_valid),
    .b_ready(b_ready), .out(out), .out_lane(out_lane), .out_last(out_last),
    .output_valid(output_valid), .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int  a_arr [4];
  bit  z_arr [4];
  int  b_arr [4][4];

  logic signed [15:0] exp_val [4];
  logic signed [15:0] got_val [4];
  int  exp_lane = 0;
  bit  drain_armed = 1'b0;

  task automatic chk(input string name, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] pack_b(input int k);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[i*16 +: 16] = 16'(b_arr[k][i]);
    return r;
  endfunction

  // Reference: exact integer dot product, wrapped to the accumulator width, scaled, then reduced
  task automatic compute_expected(input int len);
    for (int l = 0; l < 4; l++) begin
      longint s = 0;
      logic signed [31:0] acc32;
      longint v;
      for (int k = 0; k < len; k++) s += (z_arr[k] ? 0 : longint'(a_arr[k])) * longint'(b_arr[k][l]);
      acc32 = s[31:0];
      v = longint'(acc32) >>> SCALE;
`ifdef CONV_MAC_ARRAY_SATURATE_EN
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
`endif
      exp_val[l] = v[15:0];
    end
  endtask

  always @(negedge clk) begin
    if (arst_n_in && output_valid) begin
      chk("valid_expected", drain_armed, 1);
      if (drain_armed) begin
        chk("out_value", $signed(out), exp_val[exp_lane]);
        chk("out_lane", out_lane, exp_lane);
        chk("out_last", out_last, exp_lane == 3);
        chk("running_in_drain", running, 1);
        if (output_ready) begin
          got_val[exp_lane] = $signed(out);
          exp_lane++;
          if (exp_lane == 4) drain_armed = 1'b0;
        end
      end
    end
  end

  task automatic run_job(input int len, input int gap_at, input int gap_len, input int hold);
    compute_expected(len);
    exp_lane = 0;
    drain_armed = 1'b1;
    for (int i = 0; i < 4; i++) got_val[i] = 16'sh5A5A;
    start = 1'b1;
    acc_len = 16'(len);
    @(posedge clk); #1;
    start = 1'b0;
    chk("running_after_start", running, 1);
    for (int k = 0; k < len; k++) begin
      if (k == gap_at) begin
        a_valid = 1'b1; b_valid = 1'b0;
        a_input = 16'd100; a_zero_flag = 1'b0; b_input = {4{16'd9}};
        repeat (gap_len) begin
          @(negedge clk);
          chk("a_ready_gap", a_ready, 1);
          chk("b_ready_gap", b_ready, 1);
          @(posedge clk); #1;
        end
      end
      a_valid = 1'b1; b_valid = 1'b1;
      a_input = 16'(a_arr[k]); a_zero_flag = z_arr[k]; b_input = pack_b(k);
      @(negedge clk);
      chk("a_ready_beat", a_ready, 1);
      @(posedge clk); #1;
    end
    a_valid = 1'b0; b_valid = 1'b0; a_zero_flag = 1'b0;
    chk("valid_after_last_beat", output_valid, 1);
    chk("a_ready_drain", a_ready, 0);
    if (hold > 0) begin
      output_ready = 1'b0;
      start = 1'b1;
      acc_len = 16'd1;
      repeat (hold) begin @(posedge clk); #1; end
      start = 1'b0;
      chk("running_hold", running, 1);
      chk("lane_hold", out_lane, 0);
      output_ready = 1'b1;
    end
    for (int c = 0; c < 40 && drain_armed; c++) begin @(posedge clk); #1; end
    chk("drain_timeout", drain_armed, 0);
    drain_armed = 1'b0;
    chk("running_after_drain", running, 0);
    chk("valid_after_drain", output_valid, 0);
  endtask

  task automatic set_beat(input int k, input int a, input bit z, input int b0, input int b1,
                          input int b2, input int b3);
    a_arr[k] = a; z_arr[k] = z;
    b_arr[k][0] = b0; b_arr[k][1] = b1; b_arr[k][2] = b2; b_arr[k][3] = b3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_a_ready"}, a_ready, 0);
    chk({tag, "_b_ready"}, b_ready, 0);
    chk({tag, "_valid"}, output_valid, 0);
    chk({tag, "_out"}, out, 0);
    chk({tag, "_lane"}, out_lane, 0);
    chk({tag, "_last"}, out_last, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    arst_n_in = 1'b1;
    @(posedge clk); #1;

    start = 1'b1; acc_len = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("zero_len_ignored", running, 0);

    set_beat(0, 2, 0, 1, 2, 3, 4);
    set_beat(1, 3, 0, 1, 2, 3, 4);
    set_beat(2, -1, 0, 1, 2, 3, 4);
    run_job(3, -1, 0, 0);
    chk("basic_l0", got_val[0], 4);
    chk("basic_l1", got_val[1], 8);
    chk("basic_l2", got_val[2], 12);
    chk("basic_l3", got_val[3], 16);

    set_beat(0, 4, 0, 1, -1, 100, -32768);
    set_beat(1, -7, 0, 2, 3, -5, 1);
    run_job(2, 0, 5, 0);
    chk("gap_l0", got_val[0], -10);
    chk("gap_l1", got_val[1], -25);
    chk("gap_l2", got_val[2], 435);

    set_beat(0, 5, 1, 7, 7, 7, 7);
    run_job(1, -1, 0, 0);
    for (int i = 0; i < 4; i++) chk("zero_flag", got_val[i], 0);

    set_beat(0, 32767, 0, 32767, 32767, 32767, 32767);
    run_job(1, -1, 0, 0);
`ifdef CONV_MAC_ARRAY_SATURATE_EN
    chk("overflow_l0", got_val[0], 32767);
`else
    chk("overflow_l0", got_val[0], 1);
`endif

    set_beat(0, 1, 0, 10, 20, 30, 40);
    set_beat(1, 2, 0, 1, 1, 1, 1);
    run_job(2, -1, 0, 4);
    chk("hold_l0", got_val[0], 12);
    chk("hold_l3", got_val[3], 42);
    repeat (2) begin @(posedge clk); #1; end
    chk("start_in_drain_ignored", running, 0);

    start = 1'b1; acc_len = 16'd4;
    @(posedge clk); #1;
    start = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; a_input = 16'd50; b_input = {4{16'd3}};
    repeat (2) begin @(posedge clk); #1; end
    arst_n_in = 1'b0;
    #1;
    chk_reset_outputs("midjob");
    a_valid = 1'b0; b_valid = 1'b0;
    @(posedge clk); #3;
    arst_n_in = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("no_residue_running", running, 0);
    set_beat(0, 3, 0, 1, 2, 3, 4);
    run_job(1, -1, 0, 0);
    chk("fresh_l0", got_val[0], 3);
    chk("fresh_l1", got_val[1], 6);
    chk("fresh_l2", got_val[2], 9);
    chk("fresh_l3", got_val[3], 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1);
  end

endmodule
